// File: rtl/led_arb_pkg.sv
// Shared types for the LED matrix arbiter: frame type, arbiter states and grant encoding.
package led_arb_pkg;

  typedef logic [7:0][7:0] frame_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam frame_t BLANK_FRAME = '0;

  function automatic logic [1:0] grant_of(input arb_state_t s);
    case (s)
      OWN0:    grant_of = 2'b01;
      OWN1:    grant_of = 2'b10;
      default: grant_of = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/led_frame_arbiter_dwell_timer.sv
// Saturating count of frame ticks since the current owner took the display.
module dwell_timer #(
  parameter int unsigned DWELL_TICKS = 400
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int unsigned CW = (DWELL_TICKS == 0) ? 1 : $clog2(DWELL_TICKS + 1);
  localparam logic [CW-1:0] LIMIT = CW'(DWELL_TICKS);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick && (count != LIMIT)) begin
      count <= count + CW'(1);
    end
  end

  // Count never passes LIMIT, so equality is the saturation test.
  assign expired = (count == LIMIT);

endmodule

// File: rtl/led_frame_arbiter.sv
// Two-requester owner arbitration for the 8x8 LED matrix with tear-free frame latching.
module led_frame_arbiter
  import led_arb_pkg::*;
#(
  parameter int unsigned DWELL_TICKS = 400
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         tick,
  input  logic [1:0]   req,
  input  logic [7:0][7:0] red_in0,
  input  logic [7:0][7:0] green_in0,
  input  logic [7:0][7:0] red_in1,
  input  logic [7:0][7:0] green_in1,
  output logic [1:0]   grant,
  output logic         frame_load,
  output logic [7:0][7:0] red_array,
  output logic [7:0][7:0] green_array
);

  arb_state_t state;
  arb_state_t nxt;
  logic       expired;
  logic       switching;
  logic       own_tick;

  assign switching = (nxt != state);
  assign own_tick  = tick && (state != IDLE);

  dwell_timer #(
    .DWELL_TICKS(DWELL_TICKS)
  ) u_dwell (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (switching),
    .tick   (own_tick),
    .expired(expired)
  );

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (req[1])      nxt = OWN1;
        else if (req[0]) nxt = OWN0;
      end
      OWN0: begin
        if (!req[0])               nxt = req[1] ? OWN1 : IDLE;
        else if (req[1] && expired) nxt = OWN1;
      end
      OWN1: begin
        if (!req[1])               nxt = req[0] ? OWN0 : IDLE;
        else if (req[0] && expired) nxt = OWN0;
      end
      default: nxt = IDLE;
    endcase
  end

  // An ownership change takes priority over a coincident tick load from the old owner.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      grant       <= 2'b00;
      frame_load  <= 1'b0;
      red_array   <= BLANK_FRAME;
      green_array <= BLANK_FRAME;
    end else begin
      state      <= nxt;
      grant      <= grant_of(nxt);
      frame_load <= 1'b0;
      if (switching && (nxt != IDLE)) begin
        red_array   <= (nxt == OWN1) ? red_in1   : red_in0;
        green_array <= (nxt == OWN1) ? green_in1 : green_in0;
        frame_load  <= 1'b1;
      end else if (!switching && own_tick) begin
        red_array   <= (state == OWN1) ? red_in1   : red_in0;
        green_array <= (state == OWN1) ? green_in1 : green_in0;
        frame_load  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_frame_arbiter.sv
// Scoreboarded bench: stimulus queues expected frame loads, a monitor checks each frame_load pulse.
module tb_led_frame_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, tick;
  logic [1:0]  req;
  logic [63:0] red_in0, green_in0, red_in1, green_in1;
  logic [1:0]  grant;
  logic        frame_load;
  logic [63:0] red_array, green_array;

  logic        rst0, tick0;
  logic [1:0]  req0;
  logic [1:0]  grant0;
  logic        fl0;
  logic [63:0] red0, green0;

  led_frame_arbiter #(.DWELL_TICKS(3)) u_dut (
    .clock(clk), .reset_n(reset_n), .tick(tick), .req(req),
    .red_in0(red_in0), .green_in0(green_in0), .red_in1(red_in1), .green_in1(green_in1),
    .grant(grant), .frame_load(frame_load), .red_array(red_array), .green_array(green_array)
  );

  led_frame_arbiter #(.DWELL_TICKS(0)) u_dut0 (
    .clock(clk), .reset_n(rst0), .tick(tick0), .req(req0),
    .red_in0(red_in0), .green_in0(green_in0), .red_in1(red_in1), .green_in1(green_in1),
    .grant(grant0), .frame_load(fl0), .red_array(red0), .green_array(green0)
  );

  typedef struct {
    logic [63:0] r;
    logic [63:0] g;
    logic [1:0]  gr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input logic [63:0] r, input logic [63:0] g, input logic [1:0] gr);
    exp_t e;
    e.r = r; e.g = g; e.gr = gr;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Monitor: every frame_load pulse must match the oldest expected load.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (frame_load === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_load: got red %h grant %b expected no load", red_array, grant);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("load_red", red_array, e.r);
          chk("load_green", green_array, e.g);
          chk("load_grant", {62'd0, grant}, {62'd0, e.gr});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] k0, k1;
    reset_n = 1'b0; req = 2'b11; tick = 1'b1;
    red_in0 = '1; green_in0 = '1; red_in1 = '1; green_in1 = '1;
    rst0 = 1'b0; req0 = 2'b00; tick0 = 1'b0;
    cyc();

    // Reset with everything asserted
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_grant", {62'd0, grant}, 64'd0);
      chk("rst_red", red_array, 64'd0);
      chk("rst_green", green_array, 64'd0);
      chk("rst_load", {63'd0, frame_load}, 64'd0);
    end
    reset_n = 1'b1; tick = 1'b0;
    red_in1 = 64'h1111_2222_3333_4444; green_in1 = 64'hAAAA_BBBB_CCCC_DDDD;
    push(64'h1111_2222_3333_4444, 64'hAAAA_BBBB_CCCC_DDDD, 2'b10);
    cyc();
    chk("post_rst_grant", {62'd0, grant}, 64'd2);
    chk("post_rst_red", red_array, 64'h1111_2222_3333_4444);

    // Dwell of 3 ticks in OWN0 with requester 1 waiting
    req = 2'b00;
    cyc();
    chk("drop_grant", {62'd0, grant}, 64'd0);
    req = 2'b01; red_in0 = 64'h00A0; green_in0 = 64'h0A00;
    push(64'h00A0, 64'h0A00, 2'b01);
    cyc();
    chk("own0_grant", {62'd0, grant}, 64'd1);
    for (int k = 0; k < 3; k++) begin
      req = 2'b11; tick = 1'b1;
      red_in0 = 64'h00B0 + 64'(k); green_in0 = 64'h0B00 + 64'(k);
      push(64'h00B0 + 64'(k), 64'h0B00 + 64'(k), 2'b01);
      cyc();
      chk("dwell_tick_grant", {62'd0, grant}, 64'd1);
      tick = 1'b0;
      if (k < 2) begin
        cyc();
        chk("dwell_idle_grant", {62'd0, grant}, 64'd1);
      end
    end
    red_in1 = 64'h00E1; green_in1 = 64'h0E10;
    push(64'h00E1, 64'h0E10, 2'b10);
    cyc();
    chk("dwell_switch_grant", {62'd0, grant}, 64'd2);
    chk("dwell_sb_empty", 64'(sb.size()), 64'd0);

    // Release from OWN1 to IDLE, then tick while idle
    req = 2'b10;
    cyc();
    chk("own1_hold_grant", {62'd0, grant}, 64'd2);
    req = 2'b00;
    cyc();
    chk("release_grant", {62'd0, grant}, 64'd0);
    chk("release_hold_red", red_array, 64'h00E1);
    tick = 1'b1; red_in0 = 64'hDEAD; red_in1 = 64'hBEEF;
    cyc();
    tick = 1'b0;
    chk("idle_tick_red", red_array, 64'h00E1);
    chk("idle_tick_green", green_array, 64'h0E10);
    chk("idle_sb_empty", 64'(sb.size()), 64'd0);

    // Switch edge coincident with a tick
    req = 2'b01; red_in0 = 64'h0050; green_in0 = 64'h0500;
    push(64'h0050, 64'h0500, 2'b01);
    cyc();
    chk("p_grant", {62'd0, grant}, 64'd1);
    for (int k = 0; k < 3; k++) begin
      tick = 1'b1;
      red_in0 = 64'h0060 + 64'(k); green_in0 = 64'h0600 + 64'(k);
      push(64'h0060 + 64'(k), 64'h0600 + 64'(k), 2'b01);
      cyc();
      chk("solo_tick_grant", {62'd0, grant}, 64'd1);
    end
    tick = 1'b0;
    cyc();
    chk("expired_hold_grant", {62'd0, grant}, 64'd1);
    req = 2'b11; tick = 1'b1;
    red_in0 = 64'h0099; green_in0 = 64'h0990;
    red_in1 = 64'h0071; green_in1 = 64'h0710;
    push(64'h0071, 64'h0710, 2'b10);
    cyc();
    tick = 1'b0;
    chk("coinc_grant", {62'd0, grant}, 64'd2);
    chk("coinc_red", red_array, 64'h0071);
    cyc();
    chk("coinc_sb_empty", 64'(sb.size()), 64'd0);

    // Reset in the middle of OWN1 with dwell partly counted
    for (int k = 0; k < 2; k++) begin
      tick = 1'b1;
      red_in1 = 64'h0081 + 64'(k); green_in1 = 64'h0810 + 64'(k);
      push(64'h0081 + 64'(k), 64'h0810 + 64'(k), 2'b10);
      cyc();
      chk("partial_grant", {62'd0, grant}, 64'd2);
    end
    reset_n = 1'b0;
    cyc();
    chk("midrst_grant", {62'd0, grant}, 64'd0);
    chk("midrst_red", red_array, 64'd0);
    chk("midrst_green", green_array, 64'd0);
    chk("midrst_load", {63'd0, frame_load}, 64'd0);
    reset_n = 1'b1; tick = 1'b0; req = 2'b10;
    red_in1 = 64'h00F1; green_in1 = 64'h0F10;
    push(64'h00F1, 64'h0F10, 2'b10);
    cyc();
    chk("rearm_grant", {62'd0, grant}, 64'd2);
    chk("rearm_red", red_array, 64'h00F1);
    req = 2'b00;
    cyc();

    // Zero dwell: both requesting, grant alternates every cycle
    k0 = 64'h0C0C; k1 = 64'h1C1C;
    red_in0 = k0; green_in0 = ~k0; red_in1 = k1; green_in1 = ~k1;
    rst0 = 1'b1; req0 = 2'b11;
    cyc();
    chk("alt_first_grant", {62'd0, grant0}, 64'd2);
    chk("alt_first_red", red0, k1);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("alt_grant", {62'd0, grant0}, (i % 2 == 0) ? 64'd1 : 64'd2);
      chk("alt_red", red0, (i % 2 == 0) ? k0 : k1);
      chk("alt_green", green0, (i % 2 == 0) ? ~k0 : ~k1);
      chk("alt_load", {63'd0, fl0}, 64'd1);
    end
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/led_frame_arbiter.md
# led_frame_arbiter

Shares the single 8x8 red/green LED matrix between two frame producers: requester 0 is the game renderer, requester 1 is the overlay/banner layer. It grants ownership with a req/grant handshake, enforces a minimum dwell time per owner, and latches the owner's frame into the `red_array`/`green_array` registers that feed `led_matrix_driver`. Updates happen only on frame ticks, so the display never tears. It runs in the `driver_clk` domain, between the producers and the driver.

## Interface
- `DWELL_TICKS`, default 400: minimum `tick` count an owner holds the grant before it can be handed to a waiting requester. 0 means switch is allowed on any cycle.
- `clock` in 1: driver clock; all logic is on the rising edge.
- `reset_n` in 1: reset, synchronous and active-low.
- `tick` in 1: one-cycle frame strobe (the animation rate).
- `req` in 2: `req[i]` is high while requester i wants the display.
- `red_in0`, `green_in0` in [7:0][7:0]: requester 0 frame.
- `red_in1`, `green_in1` in [7:0][7:0]: requester 1 frame.
- `grant` out 2: one-hot or zero; `grant[i]` means requester i owns the display.
- `frame_load` out 1: one-cycle pulse on the cycle the output arrays change source data.
- `red_array`, `green_array` out [7:0][7:0]: frame presented to the driver.

## Operation
- States: IDLE, OWN0, OWN1. All outputs are registered.
- **Reset** (`reset_n` low at an edge): state IDLE, `grant` 0, `frame_load` 0, both arrays all-zero, dwell count 0. Reset in mid-grant aborts ownership immediately.
- **IDLE:**
  - `req[1]` set → OWN1. Requester 1 wins simultaneous requests.
  - else `req[0]` set → OWN0.
  - else stay in IDLE; arrays hold their last value.
- **OWNi, owner drops `req[i]`:**
  - other requester pending → go directly to the other OWN state.
  - otherwise → IDLE.
  - Release is immediate; dwell does not apply.
- **OWNi, owner still requesting:**
  - other requester pending and dwell count ≥ `DWELL_TICKS` → switch to the other OWN state.
  - otherwise stay.
  - After dwell expiry the grant alternates, so neither requester starves.
- **Dwell count:**
  - Cleared on every state change.
  - Increments on `tick` while in an OWN state.
  - Saturates at `DWELL_TICKS`.
  - Width is `$clog2(DWELL_TICKS+1)`, minimum 1.
- **Frame load:**
  - On the edge that enters OWNi, the arrays capture requester i's inputs and `frame_load` pulses.
  - While in OWNi, each `tick` captures requester i's inputs and pulses `frame_load`.
- **Simultaneous switch and tick:** the switch wins. The new owner's frame is loaded and the old owner's tick load is suppressed.
- **Idle:** `frame_load` never pulses in IDLE.

## Timing
- Grant latency: `req` sampled high at edge N → `grant` high after edge N, so it is visible in cycle N+1.
- Arrays update on the same edge that asserts the grant. `frame_load` is high for exactly that cycle.
- Release latency: `req[i]` low at edge N → `grant[i]` low after edge N.
- No cycle ever has both grant bits high. A direct switch changes `grant` from 01 to 10 in one edge, with no gap.
- Tick loads: data sampled at edge N (where `tick` is high) appears on the arrays after edge N.
- Dwell: with `DWELL_TICKS`=D, the earliest handoff is the edge after the owner's D-th tick. That tick's load happens first; the switch occurs at the following edge, provided the other requester is still pending.
- `tick` arriving during reset is ignored.

## Structure
- Package `led_arb_pkg`:
  - typedef `frame_t` = `logic [7:0][7:0]`.
  - enum `arb_state_t` {IDLE, OWN0, OWN1}.
  - constant `BLANK_FRAME` = '0.
- One sub-module, `dwell_timer`:
  - inputs: `clock`, `reset_n`, `clear`, `tick`.
  - output: `expired`.
  - parameter: `DWELL_TICKS`.
  - saturating count as specified above.
- Top contains the FSM and the frame mux/registers only.

## Test plan
- Reset with all-ones inputs and `req`=11 held → `grant`=00, arrays zero, `frame_load`=0 throughout reset; after release, OWN1 one edge later with arrays = `red_in1`/`green_in1`.
- `DWELL_TICKS`=3, OWN0 held, `req[1]` raised at tick 1 → `grant` stays 01 through the 3rd tick, then becomes 10 on the next edge. Exactly 4 `frame_load` pulses come from requester 0 (entry plus 3 ticks).
- OWN1 with `req[0]`=0; drop `req[1]` → `grant`=00 next edge; arrays hold the last frame; a later `tick` produces no `frame_load`.
- Dwell expired in OWN0, `req[1]` pending, and `tick` coincident with the switch edge → a single `frame_load`, arrays = requester 1 frame.
- `DWELL_TICKS`=0, both requesting continuously → `grant` alternates 10,01,10,… every cycle, never 11 or 00.
- Assert reset mid-OWN1 with dwell partially counted → next edge: IDLE, count 0, arrays zero.
